// File: rtl/rv_m_pkg.sv
// Shared RV32M decode constants, FSM state encoding and funct3 classification helpers.
package rv_m_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU};
  endfunction

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3 inside {F3_REM, F3_REMU};
  endfunction

  function automatic logic is_mul_hi(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_MULHSU, F3_MULHU};
  endfunction

  function automatic logic rs1_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/m_unit_seq_if.sv
// Request/response bundle between the core's M-format operand path and the multiply/divide unit.
interface m_unit_seq_if;

  logic        iVALID;
  logic        oREADY;
  logic [31:0] iIR;
  logic [31:0] iALU_IN1_M;
  logic [31:0] iALU_IN2_M;
  logic        oVALID;
  logic        iREADY;
  logic [31:0] oALU_OUT_M;
  logic [4:0]  oRD_M;
  logic        oBUSY;

  modport slave (
    input  iVALID, iIR, iALU_IN1_M, iALU_IN2_M, iREADY,
    output oREADY, oVALID, oALU_OUT_M, oRD_M, oBUSY
  );

  modport master (
    output iVALID, iIR, iALU_IN1_M, iALU_IN2_M, iREADY,
    input  oREADY, oVALID, oALU_OUT_M, oRD_M, oBUSY
  );

endinterface

// File: rtl/m_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and final sign correction.
module m_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/m_unit_seq.sv
// Sequential RV32M unit: shift-add multiplier and restoring divider, one bit per cycle,
// with a single-entry valid/ready request and result handshake.
module m_unit_seq
  import rv_m_pkg::*;
(
  input  logic          iCLK,
  input  logic          iRST_N,
  m_unit_seq_if.slave   bus
);

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] op_q, op_d;
  logic [31:0] out_q, out_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        neg_q, neg_d;

  logic [2:0]  f3_in;
  logic        accept, a_neg, b_neg, div_zero, div_ovf, rem_ge;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, part_rem;
  logic [63:0] fix_in, fix_out;

  assign f3_in  = bus.iIR[14:12];
  assign accept = bus.iVALID && (state_q == IDLE) &&
                  (bus.iIR[6:0] == OPC_OP) && (bus.iIR[31:25] == F7_MULDIV);

  assign a_neg = rs1_signed(f3_in) & bus.iALU_IN1_M[31];
  assign b_neg = rs2_signed(f3_in) & bus.iALU_IN2_M[31];

  m_sign_fix #(.W(32)) u_mag_a (.neg_i(a_neg), .val_i(bus.iALU_IN1_M), .val_o(mag_a));
  m_sign_fix #(.W(32)) u_mag_b (.neg_i(b_neg), .val_i(bus.iALU_IN2_M), .val_o(mag_b));

  assign div_zero = is_div_op(f3_in) && (bus.iALU_IN2_M == 32'd0);
  assign div_ovf  = (f3_in inside {F3_DIV, F3_REM}) &&
                    (bus.iALU_IN1_M == 32'h8000_0000) && (bus.iALU_IN2_M == 32'hFFFF_FFFF);

  // acc_q[31:0] starts as multiplier (mul) or dividend (div) and is shifted out as bits are consumed.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, op_q} : 33'd0);
  assign part_rem = {rem_q, acc_q[31]};
  assign rem_ge   = (part_rem >= {1'b0, op_q});

  assign fix_in = is_mul_op(f3_q) ? acc_q :
                  is_rem_op(f3_q) ? {32'd0, rem_q} : {32'd0, acc_q[31:0]};

  m_sign_fix #(.W(64)) u_fix (.neg_i(neg_q), .val_i(fix_in), .val_o(fix_out));

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    out_d   = out_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    neg_d   = neg_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d    = f3_in;
          rd_d    = bus.iIR[11:7];
          count_d = 5'd0;
          acc_d   = {32'd0, mag_a};
          rem_d   = 32'd0;
          op_d    = mag_b;
          neg_d   = is_rem_op(f3_in) ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            out_d   = is_rem_op(f3_in) ? bus.iALU_IN1_M : 32'hFFFF_FFFF;
            state_d = DONE;
          end else if (div_ovf) begin
            out_d   = is_rem_op(f3_in) ? 32'd0 : 32'h8000_0000;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        count_d = count_q + 5'd1;
        if (is_mul_op(f3_q)) begin
          acc_d = {mul_sum, acc_q[31:1]};
        end else begin
          acc_d[31:0] = {acc_q[30:0], rem_ge};
          rem_d       = rem_ge ? (part_rem[31:0] - op_q) : part_rem[31:0];
        end
        if (count_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        out_d   = is_mul_hi(f3_q) ? fix_out[63:32] : fix_out[31:0];
        state_d = DONE;
      end
      DONE: begin
        if (bus.iREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge and clears every register, datapath included,
  // so an aborted operation leaves nothing visible behind.
  always_ff @(posedge iCLK) begin
    // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
    if (!iRST_N) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      out_q   <= out_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.oREADY     = (state_q == IDLE);
  assign bus.oBUSY      = (state_q != IDLE);
  assign bus.oVALID     = (state_q == DONE);
  assign bus.oALU_OUT_M = out_q;
  assign bus.oRD_M      = rd_q;

endmodule

// File: tb/tb_m_unit_seq.sv
// Self-checking bench for m_unit_seq: directed RV32M corner cases, randomized operations
// against an arithmetic reference model, backpressure, ignored requests and mid-operation reset.
module tb_m_unit_seq;
  import rv_m_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m_unit_seq_if bus ();

  m_unit_seq dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_ir;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam vec_t DIR_VEC [12] = '{
    '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{F3_DIVU,   32'd100,       32'd7,         32'd14},
    '{F3_REMU,   32'd100,       32'd7,         32'd2},
    '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF},
    '{F3_REM,    32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFF6}
  };

  // Reference model: RV32M semantics expressed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    t  = 64'd0;
    case (f3)
      F3_MUL:    begin t = ua * ub;             return t[31:0];  end
      F3_MULH:   begin t = sa * sb;             return t[63:32]; end
      F3_MULHSU: begin t = sa * longint'(ub);   return t[63:32]; end
      F3_MULHU:  begin t = ua * ub;             return t[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        t = sa / sb; return t[31:0];
      end
      F3_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        t = sa % sb; return t[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 32'd0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [4:0] rd);
    logic [9:0] regs;
    regs = 10'($urandom);
    return {F7_MULDIV, regs, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues one request from an idle DUT, reports result, rd and latency (1 = cycle after accept edge).
  task automatic run_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        output logic [31:0] res, output logic [4:0] rd_o, output int lat);
    bus.iIR        = mk_ir(f3, rd);
    last_ir        = bus.iIR;
    bus.iALU_IN1_M = a;
    bus.iALU_IN2_M = b;
    bus.iVALID     = 1'b1;
    @(posedge clk); #1;
    bus.iVALID     = 1'b0;
    bus.iIR        = $urandom;
    bus.iALU_IN1_M = $urandom;
    bus.iALU_IN2_M = $urandom;
    lat = 1;
    while (!bus.oVALID && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = bus.oALU_OUT_M;
    rd_o = bus.oRD_M;
    repeat (hold) begin @(posedge clk); #1; end
    bus.iREADY = 1'b1;
    @(posedge clk); #1;
    bus.iREADY = 1'b0;
  endtask

  task automatic test_reset;
    logic [39:0] got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.oREADY, bus.oVALID, bus.oBUSY, bus.oALU_OUT_M, bus.oRD_M};
    vectors++;
    if (got !== {1'b1, 1'b0, 1'b0, 32'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_hold: {rdy,vld,busy,out,rd} got %h want %h", got, {1'b1, 1'b0, 1'b0, 32'd0, 5'd0});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    got = {bus.oREADY, bus.oVALID, bus.oBUSY, bus.oALU_OUT_M, bus.oRD_M};
    vectors++;
    if (got !== {1'b1, 1'b0, 1'b0, 32'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_release: {rdy,vld,busy,out,rd} got %h want %h", got, {1'b1, 1'b0, 1'b0, 32'd0, 5'd0});
    end
  endtask

  task automatic test_directed;
    logic [31:0] res;
    logic [4:0]  rd_o;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      run_op(DIR_VEC[i].f3, 5'(i * 3), DIR_VEC[i].a, DIR_VEC[i].b, 0, res, rd_o, lat);
      vectors++;
      if (res !== DIR_VEC[i].exp) begin
        miscompares++;
        $display("FAIL dir%0d result f3=%0d a=%h b=%h: got %h want %h",
                 i, DIR_VEC[i].f3, DIR_VEC[i].a, DIR_VEC[i].b, res, DIR_VEC[i].exp);
      end
      vectors++;
      if (rd_o !== last_ir[11:7]) begin
        miscompares++;
        $display("FAIL dir%0d rd: got %0d want %0d", i, rd_o, last_ir[11:7]);
      end
      vectors++;
      if (lat != ref_latency(DIR_VEC[i].f3, DIR_VEC[i].a, DIR_VEC[i].b)) begin
        miscompares++;
        $display("FAIL dir%0d latency: got %0d want %0d", i, lat,
                 ref_latency(DIR_VEC[i].f3, DIR_VEC[i].a, DIR_VEC[i].b));
      end
    end
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a, b, res, want;
    logic [4:0]  rd_o;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      rd = 5'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      want = ref_result(f3, a, b);
      run_op(f3, rd, a, b, $urandom_range(0, 3), res, rd_o, lat);
      vectors++;
      if (res !== want || rd_o !== rd || lat != ref_latency(f3, a, b)) begin
        miscompares++;
        $display("FAIL rand%0d f3=%0d a=%h b=%h: got res=%h rd=%0d lat=%0d want res=%h rd=%0d lat=%0d",
                 i, f3, a, b, res, rd_o, lat, want, rd, ref_latency(f3, a, b));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] want;
    logic [33:0] got;
    int          wait_cyc;
    // Non-M requests in IDLE: ADD (funct7 0) then OP-IMM with the M funct7.
    bus.iVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.iIR = (i < 3) ? {7'h00, 10'h155, F3_MUL, 5'd4, OPC_OP} : {F7_MULDIV, 10'h0AA, F3_DIV, 5'd6, 7'b0010011};
      @(posedge clk); #1;
      vectors++;
      if ({bus.oREADY, bus.oBUSY, bus.oVALID} !== 3'b100) begin
        miscompares++;
        $display("FAIL ignore_idle%0d: {rdy,busy,vld} got %b want 100", i, {bus.oREADY, bus.oBUSY, bus.oVALID});
      end
    end
    want = ref_result(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    bus.iIR        = mk_ir(F3_MULHU, 5'd9);
    bus.iALU_IN1_M = 32'h1234_5678;
    bus.iALU_IN2_M = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    // Keep iVALID high with a non-M instruction while the unit is busy.
    bus.iIR = {7'h00, 10'h3FF, F3_MUL, 5'd1, OPC_OP};
    wait_cyc = 1;
    while (!bus.oVALID && wait_cyc < 60) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    vectors++;
    if (wait_cyc != 34) begin
      miscompares++;
      $display("FAIL bp_latency: got %0d want 34", wait_cyc);
    end
    for (int i = 0; i < 10; i++) begin
      got = {bus.oVALID, bus.oREADY, bus.oALU_OUT_M};
      vectors++;
      if (got !== {1'b1, 1'b0, want}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: {vld,rdy,out} got %h want %h", i, got, {1'b1, 1'b0, want});
      end
      @(posedge clk); #1;
    end
    // Valid M request presented during the result handshake must not be taken on that edge.
    bus.iIR    = mk_ir(F3_MUL, 5'd2);
    bus.iREADY = 1'b1;
    @(posedge clk); #1;
    bus.iREADY = 1'b0;
    bus.iVALID = 1'b0;
    vectors++;
    if ({bus.oREADY, bus.oBUSY, bus.oVALID} !== 3'b100) begin
      miscompares++;
      $display("FAIL bp_release: {rdy,busy,vld} got %b want 100", {bus.oREADY, bus.oBUSY, bus.oVALID});
    end
  endtask

  task automatic test_mid_reset;
    logic [39:0] got;
    logic        saw_valid;
    logic [31:0] res;
    logic [4:0]  rd_o;
    int          lat;
    bus.iIR        = mk_ir(F3_DIVU, 5'd17);
    bus.iALU_IN1_M = 32'd1000;
    bus.iALU_IN2_M = 32'd3;
    bus.iVALID     = 1'b1;
    @(posedge clk); #1;
    bus.iVALID = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    got = {bus.oREADY, bus.oVALID, bus.oBUSY, bus.oALU_OUT_M, bus.oRD_M};
    vectors++;
    if (got !== {1'b1, 1'b0, 1'b0, 32'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL midrst_state: {rdy,vld,busy,out,rd} got %h want %h", got, {1'b1, 1'b0, 1'b0, 32'd0, 5'd0});
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      saw_valid |= bus.oVALID;
    end
    vectors++;
    if (saw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_no_result: oVALID seen %b want 0", saw_valid);
    end
    run_op(F3_MUL, 5'd5, 32'd3, 32'd4, 0, res, rd_o, lat);
    vectors++;
    if (res !== 32'd12 || rd_o !== 5'd5 || lat != 34) begin
      miscompares++;
      $display("FAIL midrst_mul: got res=%h rd=%0d lat=%0d want res=0000000c rd=5 lat=34", res, rd_o, lat);
    end
  endtask

  initial begin
    bus.iVALID     = 1'b0;
    bus.iREADY     = 1'b0;
    bus.iIR        = '0;
    bus.iALU_IN1_M = '0;
    bus.iALU_IN2_M = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m_unit_seq.md
# m_unit_seq

Sequential RV32M multiply/divide responder for the core's M-format operand path. It accepts one R-type M instruction at a time, consisting of the instruction word plus the two M-format operands. It iterates a shift-add multiplier or a restoring divider and returns the 32-bit result and destination register over a valid/ready handshake. The result feeds the M-format ALU-output slot of the instruction mux.

## Interface
- No parameters; XLEN fixed at 32.
- iCLK  in  1  clock; all state updates on rising edge
- iRST_N  in  1  reset: synchronous, active-low
- iVALID  in  1  request valid
- oREADY  out  1  unit idle, request may be accepted
- iIR  in  32  instruction word; opcode [6:0], rd [11:7], funct3 [14:12], funct7 [31:25]
- iALU_IN1_M  in  32  rs1 operand
- iALU_IN2_M  in  32  rs2 operand
- oVALID  out  1  result valid
- iREADY  in  1  consumer accepts result
- oALU_OUT_M  out  32  result
- oRD_M  out  5  destination register of result
- oBUSY  out  1  request in flight (state != IDLE)

## Operation
- Accept occurs when iVALID & oREADY & iIR[6:0]==0110011 & iIR[31:25]==0000001. A request with any other opcode/funct7 is ignored and gets no response.
- On accept, latch funct3, rd, operand magnitudes and result sign.
- funct3 map:
  - 000 MUL: low 32 bits of product
  - 001 MULH: high 32 bits, signed×signed
  - 010 MULHSU: high 32 bits, signed rs1 × unsigned rs2
  - 011 MULHU: high 32 bits, unsigned×unsigned
  - 100 DIV, 101 DIVU: quotient
  - 110 REM, 111 REMU: remainder
- Signed ops work on absolute values. The final result is negated in FIX:
  - product when the operand signs differ
  - quotient when the operand signs differ
  - remainder when the dividend is negative
- Divisor zero: quotient 0xFFFFFFFF, remainder = dividend, unsigned and signed alike.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Both special cases bypass CALC.
- Multiply: 64-bit accumulator; one multiplier bit per cycle, LSB first.
- Divide: restoring; one quotient bit per cycle, MSB first; 33-bit partial remainder.
- States:
  - IDLE: oREADY=1. Accept → CALC (count=0), or → DONE for a special case.
  - CALC: count++ each cycle; after 32 iterations (count==31) → FIX.
  - FIX: sign-correct, select hi/lo or quotient/remainder, load oALU_OUT_M → DONE.
  - DONE: oVALID=1; output held stable until iREADY → IDLE.

## Timing
- Reset: state IDLE; oREADY=1; oVALID=0; oBUSY=0; oALU_OUT_M=0; oRD_M=0; all datapath registers cleared.
- Reset dominates in every state. A mid-operation reset discards the operation with no response.
- Normal latency: oVALID first high 34 cycles after the accept edge (32 CALC + FIX + DONE entry).
- Special-case latency: oVALID high in the cycle after the accept edge.
- oREADY is low from the cycle after accept until the cycle after the result handshake. A new request is never accepted in the same cycle as a result handshake.
- oVALID stays high with a constant result while iREADY=0, with no limit.
- oREADY and oBUSY are functions of state only. No combinational path from iVALID/iREADY to any output.
- rd=0 is not special-cased; the result is returned with oRD_M=0.

## Structure
- Shared package rv_m_pkg holds:
  - OPC_OP=7'b0110011, F7_MULDIV=7'h01
  - funct3 constants F3_MUL..F3_REMU
  - state encoding (IDLE, CALC, FIX, DONE), 2-bit
- One combinational sub-module m_sign_fix: conditional two's-complement negate (32/64-bit) used at accept and in FIX.
- Everything else stays in m_unit_seq.

## Test plan
- MUL 7 × 0xFFFFFFFD: 0xFFFFFFEB, oRD_M = rd, oVALID exactly 34 cycles after accept.
- MULH 0x80000000 × 0x80000000: 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF: 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF: 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2: 0xFFFFFFFD.
- REM 0xFFFFFFF9 % 2: 0xFFFFFFFF.
- DIVU 100 / 7: 14.
- REMU 100 % 7: 2.
- DIV 0x80000000 / 0xFFFFFFFF: 0x80000000, latency 1.
- REM same operands: 0.
- DIVU 5 / 0: 0xFFFFFFFF.
- REM 0xFFFFFFF6 % 0: 0xFFFFFFF6, latency 1.
- Backpressure: iREADY low for 10 cycles in DONE. Result stays constant and oREADY stays 0. A non-M opcode with iVALID high is ignored, both in IDLE and while busy.
- iRST_N low for one cycle mid-CALC: next cycle IDLE with all outputs at reset values and no result emitted. A subsequent MUL 3 × 4 returns 12.
